lly_vm_param: RTL

LLY_VM_PARAM -- requirements
Module: lly_vm_param

---
 rtl/lly_vm_pkg.sv | 18 +
 rtl/lly_coin_edge.sv | 45 ++++
 rtl/lly_vm_param.sv | 133 +++++++++++++
 3 files changed

// File: rtl/lly_vm_pkg.sv
// Shared definitions for the lly_vm_param vending machine.
// Contents: the FSM state encoding and the D_in coin code constants.
// Build option: VM_CHANGE_EN (see lly_vm_param) does not affect this file.
package lly_vm_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StVend    = 2'd2,
    StChange  = 2'd3
  } vm_state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_HALF = 2'b01;
  localparam logic [1:0] COIN_ONE  = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

endpackage

// File: rtl/lly_coin_edge.sv
// Coin event detector for the vending machine.
// A coin event is a nonzero D_in code whose previous sample was COIN_NONE, so a
// code held for several cycles counts once. Also decodes the coin value.
// Ports:
//   clk_i        system clock (rising edge)
//   rst_i        asynchronous active-high reset, clears the history to COIN_NONE
//   d_in_i       raw coin code
//   coin_evt_o   a coin event occurs at this edge
//   coin_val_o   value in half-yuan units (0, 1 or 2)
//   coin_bad_o   code is COIN_BAD
// Build option: VM_CHANGE_EN does not affect this file.
module lly_coin_edge
  import lly_vm_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] d_in_i,
  output logic       coin_evt_o,
  output logic [1:0] coin_val_o,
  output logic       coin_bad_o
);

  logic [1:0] d_in_prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d_in_prev_q <= COIN_NONE;
    end else begin
      d_in_prev_q <= d_in_i;
    end
  end

  assign coin_evt_o = (d_in_i != COIN_NONE) && (d_in_prev_q == COIN_NONE);
  assign coin_bad_o = (d_in_i == COIN_BAD);

  always_comb begin
    coin_val_o = 2'd0;
    case (d_in_i)
      COIN_HALF: coin_val_o = 2'd1;
      COIN_ONE:  coin_val_o = 2'd2;
      default:   coin_val_o = 2'd0;
    endcase
  end

endmodule

// File: rtl/lly_vm_param.sv
// Parameterised vending machine: collects half-yuan / one-yuan coins, vends one
// item when credit reaches PRICE, and returns change or refunds one half-yuan
// per cycle on D_C.
// Parameters: PRICE (item price, half-yuan units), CREDIT_W (credit width).
// Ports:
//   Clk       system clock (rising edge)
//   Reset     asynchronous active-high reset
//   D_in      coin code (00 none, 01 half, 10 one, 11 invalid)
//   Cancel    refund request, honoured only while collecting
//   D_out     vend pulse, one cycle per item
//   D_C       change/refund pulse, one cycle per half-yuan returned
//   Credit    current credit, half-yuan units
//   Busy      high while vending or returning change
//   Coin_rej  one-cycle pulse after a rejected coin event
// Build option: define VM_CHANGE_EN to return overpayment as change after a
// vend; otherwise residual credit is kept and collection continues.
module lly_vm_param
  import lly_vm_pkg::*;
#(
  parameter int unsigned PRICE    = 5,
  parameter int unsigned CREDIT_W = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [1:0]          D_in,
  input  logic                Cancel,
  output logic                D_out,
  output logic                D_C,
  output logic [CREDIT_W-1:0] Credit,
  output logic                Busy,
  output logic                Coin_rej
);

  localparam logic [CREDIT_W-1:0] PriceC = CREDIT_W'(PRICE);

  vm_state_e           state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic                d_out_q;
  logic                d_c_q;
  logic                busy_q;
  logic                coin_rej_q;

  logic                coin_evt;
  logic [1:0]          coin_val;
  logic                coin_bad;
  logic [CREDIT_W-1:0] credit_add;
  logic [CREDIT_W-1:0] credit_rem;

  lly_coin_edge u_coin_edge (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .d_in_i     (D_in),
    .coin_evt_o (coin_evt),
    .coin_val_o (coin_val),
    .coin_bad_o (coin_bad)
  );

  // Credit never exceeds PRICE+1, so neither sum nor difference wraps.
  assign credit_add = credit_q + CREDIT_W'(coin_val);
  assign credit_rem = credit_q - PriceC;

  // Outputs are registered alongside the state so they follow it exactly.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      credit_q   <= '0;
      d_out_q    <= 1'b0;
      d_c_q      <= 1'b0;
      busy_q     <= 1'b0;
      coin_rej_q <= 1'b0;
    end else begin
      d_out_q    <= 1'b0;
      d_c_q      <= 1'b0;
      busy_q     <= 1'b0;
      coin_rej_q <= 1'b0;
      case (state_q)
        StIdle, StCollect: begin
          if (Cancel && (state_q == StCollect)) begin
            // Refund wins over a simultaneous coin, which is rejected.
            state_q    <= StChange;
            d_c_q      <= 1'b1;
            busy_q     <= 1'b1;
            coin_rej_q <= coin_evt;
          end else if (coin_evt && !coin_bad) begin
            credit_q <= credit_add;
            if (credit_add >= PriceC) begin
              state_q <= StVend;
              d_out_q <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= StCollect;
            end
          end else if (coin_evt) begin
            coin_rej_q <= 1'b1;
          end
        end
        StVend: begin
          coin_rej_q <= coin_evt;
          credit_q   <= credit_rem;
          if (credit_rem != '0) begin
`ifdef VM_CHANGE_EN
            state_q <= StChange;
            d_c_q   <= 1'b1;
            busy_q  <= 1'b1;
`else
            state_q <= StCollect;
`endif
          end else begin
            state_q <= StIdle;
          end
        end
        StChange: begin
          coin_rej_q <= coin_evt;
          credit_q   <= credit_q - 1'b1;
          if (credit_q == CREDIT_W'(1)) begin
            state_q <= StIdle;
          end else begin
            d_c_q  <= 1'b1;
            busy_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign D_out    = d_out_q;
  assign D_C      = d_c_q;
  assign Credit   = credit_q;
  assign Busy     = busy_q;
  assign Coin_rej = coin_rej_q;

endmodule
